mem_bus_arbiter: RTL

- Shares the single block-wide data memory (32-bit blocks, 6-bit block address, busywait handshake) between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache controllers and the data memory.
- Grants one requester at a time, registers its command, and sequences the memory transaction to completion.
- Returns read data and releases the winner's busywait for exactly one cycle.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between icache and dcache requests.
// ARB_ROUND_ROBIN_EN: alternate on contention using the last-grant bit;
// otherwise the dcache always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic last_grant_i,
  output logic win_d_c_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // On contention favour whoever was not granted last; single requests win outright.
  always_comb begin
    win_d_c_o = req_d_i;
    if (req_i_i && req_d_i) begin
      win_d_c_o = (last_grant_i == REQ_I);
    end
  end
`else
  // Fixed priority: a valid dcache request always wins.
  logic unused_pick_c;
  assign unused_pick_c = req_i_i ^ last_grant_i;
  assign win_d_c_o     = req_d_i;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one block-wide data memory between the icache (read-only) and the
// dcache (read/write-back). Grants one requester, registers its command and
// runs the busywait handshake to completion.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration (see mem_arb_pick).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = mem_arb_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  arb_state_e            state_q, state_d;
  logic                  seen_busy_q, seen_busy_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_WIDTH-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_WIDTH-1:0] d_readdata_q, d_readdata_d;

  logic d_req_c;
  logic d_cmd_c;
  logic win_d_c;

  // A grantable dcache command has exactly one strobe; any strobe keeps the dcache stalled,
  // so a malformed read+write command is never acknowledged.
  assign d_req_c = d_read ^ d_write;
  assign d_cmd_c = d_read | d_write;

  assign i_busywait    = i_read  && (state_q != DONE_I);
  assign d_busywait    = d_cmd_c && (state_q != DONE_D);
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;

  mem_arb_pick u_pick (
    .req_i_i      (i_read),
    .req_d_i      (d_req_c),
    .last_grant_i (last_grant_q),
    .win_d_c_o    (win_d_c)
  );

  // Next-state and registered-command logic for the grant/complete sequence.
  always_comb begin
    state_d         = state_q;
    seen_busy_d     = seen_busy_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;

    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (i_read || d_req_c) begin
          seen_busy_d = 1'b0;
          if (win_d_c) begin
            mem_read_d      = d_read;
            mem_write_d     = d_write;
            mem_address_d   = d_address;
            mem_writedata_d = d_writedata;
            last_grant_d    = REQ_D;
            state_d         = GRANT_D;
          end else begin
            mem_read_d    = 1'b1;
            mem_address_d = i_address;
            last_grant_d  = REQ_I;
            state_d       = GRANT_I;
          end
        end
      end

      GRANT_I: begin
        if (seen_busy_q && !mem_busywait) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          i_readdata_d = mem_readdata;
          state_d      = DONE_I;
        end else if (mem_busywait) begin
          seen_busy_d = 1'b1;
        end
      end

      GRANT_D: begin
        if (seen_busy_q && !mem_busywait) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            d_readdata_d = mem_readdata;
          end
          state_d = DONE_D;
        end else if (mem_busywait) begin
          seen_busy_d = 1'b1;
        end
      end

      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and command registers; reset abandons any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      seen_busy_q     <= 1'b0;
      last_grant_q    <= REQ_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      seen_busy_q     <= seen_busy_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end

endmodule
